// File: rtl/work_dispatch_uart_pkg.sv
// Shared definitions for the work-dispatch UART: FSM encodings, packet/nonce sizes,
// receive-timeout length and the clocks-per-bit derivation.
package work_dispatch_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int WORK_BYTES   = 64;
  localparam int NONCE_BYTES  = 4;
  localparam int TIMEOUT_BITS = 20;

  // Clocks per UART bit; callers must keep the result >= 4 so a half-bit exists.
  function automatic int calc_bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/work_dispatch_byte_rx.sv
// 8N1 byte receiver: two-flop RxD synchronizer, start-bit glitch rejection,
// centre-of-bit sampling and stop-bit framing check. rx_state is the live FSM state.
module work_dispatch_byte_rx
  import work_dispatch_uart_pkg::*;
#(
  parameter int BIT_CYCLES = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output rx_state_t  rx_state
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);

  rx_state_t      rx_next;
  logic           rxd_s1, rxd_s2, rxd_s3;
  logic           fall;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           sample_pt;
  logic           byte_done;
  logic           frame_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  assign fall = rxd_s3 & ~rxd_s2;

  always_ff @(posedge clk) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // A high line at the half-bit point means the start edge was a glitch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (fall) rx_next = RX_START;
      RX_START: if (sample_pt) rx_next = rxd_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (sample_pt && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (sample_pt) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    sample_pt = 1'b0;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    case (rx_state)
      RX_START: sample_pt = (cnt == HALF_LAST);
      RX_DATA:  sample_pt = (cnt == BIT_LAST);
      RX_STOP:  sample_pt = (cnt == BIT_LAST);
      default:  sample_pt = 1'b0;
    endcase
    if (rx_state == RX_STOP && sample_pt) begin
      byte_done = rxd_s2;
      frame_bad = ~rxd_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= byte_done;
      frame_err  <= frame_bad;
      if (rx_state == RX_IDLE || sample_pt) cnt <= '0;
      else                                  cnt <= cnt + 1'b1;
      if (rx_state == RX_DATA && sample_pt) begin
        shreg   <= {rxd_s2, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (byte_done) rx_byte <= shreg;
    end
  end

endmodule

// File: rtl/work_dispatch_uart.sv
// Host-side miner work link: sends {midstate, data2} as 64 UART bytes and assembles
// 4-byte little-endian golden nonces. Optional: WORK_DISPATCH_RX_TIMEOUT_EN drops stale partial nonces.
module work_dispatch_uart
  import work_dispatch_uart_pkg::*;
#(
  parameter int comm_clk_frequency = 50_000_000,
  parameter int baud_rate          = 115_200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] midstate,
  input  logic [255:0] data2,
  output logic         TxD,
  input  logic         RxD,
  output logic [31:0]  nonce,
  output logic         nonce_valid,
  output logic         rx_frame_err,
  output logic         tx_busy
);

  localparam int BIT_CYCLES = calc_bit_cycles(comm_clk_frequency, baud_rate);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [5:0]    LAST_BYTE = 6'(WORK_BYTES - 1);
  localparam logic [1:0]    LAST_NB   = 2'(NONCE_BYTES - 1);

  // Work handshake: a unit transfers on any edge where work_valid && work_ready;
  // work_ready is high only while the transmitter is idle, so nothing is queued.
  tx_state_t      tx_state, tx_next;
  logic           accept;
  logic           tick_done;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [2:0]     data_idx;
  logic [5:0]     byte_idx;
  logic [511:0]   tx_shreg;
  logic [7:0]     cur_byte;
  logic           txd_d;

  assign work_ready = (tx_state == TX_IDLE) && !reset;
  assign accept     = work_valid && work_ready;
  assign tick_done  = (baud_cnt == BIT_LAST);
  assign tx_busy    = (tx_state != TX_IDLE);
  assign cur_byte   = tx_shreg[511:504];

  always_ff @(posedge clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (accept) tx_next = TX_START;
      TX_START: if (tick_done) tx_next = TX_DATA;
      TX_DATA:  if (tick_done && bit_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tick_done) tx_next = (byte_idx == LAST_BYTE) ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TxD is registered, so the line level is computed from the state being entered.
  always_comb begin
    data_idx = (tx_state == TX_DATA && tick_done) ? bit_idx + 3'd1 : bit_idx;
    case (tx_next)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = cur_byte[data_idx];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      TxD      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx_shreg <= '0;
    end else begin
      TxD <= txd_d;
      if (accept) begin
        tx_shreg <= {midstate, data2};
        baud_cnt <= '0;
        bit_idx  <= '0;
        byte_idx <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tick_done) begin
          baud_cnt <= '0;
          if (tx_state == TX_DATA) bit_idx <= bit_idx + 3'd1;
          if (tx_state == TX_STOP) begin
            tx_shreg <= {tx_shreg[503:0], 8'h00};
            byte_idx <= byte_idx + 6'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  rx_state_t   rx_dbg_state;
  logic        rx_busy;
  logic        rx_timeout;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;

  work_dispatch_byte_rx #(.BIT_CYCLES(BIT_CYCLES)) u_byte_rx (
    .clk        (clk),
    .reset      (reset),
    .rxd        (RxD),
    .rx_byte    (rx_byte),
    .byte_valid (rx_byte_valid),
    .frame_err  (rx_frame_err),
    .rx_state   (rx_dbg_state)
  );

  assign rx_busy = (rx_dbg_state != RX_IDLE);

`ifdef WORK_DISPATCH_RX_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BITS * BIT_CYCLES;
  localparam int TW = $clog2(TO_CYCLES);
  logic [TW-1:0] to_cnt;

  // Runs only while a partial nonce is held and the receiver sits idle.
  always_ff @(posedge clk) begin
    if (reset || byte_cnt == 2'd0 || rx_busy) to_cnt <= '0;
    else if (!rx_timeout)                      to_cnt <= to_cnt + 1'b1;
  end

  assign rx_timeout = (to_cnt == TW'(TO_CYCLES - 1));
`else
  logic unused_rx_busy;
  assign unused_rx_busy = rx_busy;
  assign rx_timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt    <= '0;
      partial     <= '0;
      nonce       <= '0;
      nonce_valid <= 1'b0;
    end else begin
      nonce_valid <= 1'b0;
      if (rx_byte_valid) begin
        partial <= {rx_byte, partial[23:8]};
        if (byte_cnt == LAST_NB) begin
          nonce       <= {rx_byte, partial};
          nonce_valid <= 1'b1;
          byte_cnt    <= '0;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
        end
      end else if (rx_timeout) begin
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_work_dispatch_uart.sv
// Directed bench for work_dispatch_uart at 10 clocks per bit: TX packet decode,
// handshake timing, mid-packet reset, nonce assembly, framing error and partial-nonce handling.
module tb_work_dispatch_uart;

  localparam int BC = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         work_valid = 1'b0;
  logic         work_ready;
  logic [255:0] midstate = '0;
  logic [255:0] data2 = '0;
  logic         TxD;
  logic         RxD = 1'b1;
  logic [31:0]  nonce;
  logic         nonce_valid;
  logic         rx_frame_err;
  logic         tx_busy;

  work_dispatch_uart #(
    .comm_clk_frequency (1_000_000),
    .baud_rate          (100_000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .work_valid   (work_valid),
    .work_ready   (work_ready),
    .midstate     (midstate),
    .data2        (data2),
    .TxD          (TxD),
    .RxD          (RxD),
    .nonce        (nonce),
    .nonce_valid  (nonce_valid),
    .rx_frame_err (rx_frame_err),
    .tx_busy      (tx_busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected nonces in order of arrival
  logic [31:0] exp_q[$];
  int nv_count = 0;
  int fe_count = 0;
  logic [31:0] exp_n;

  always @(negedge clk) begin
    if (!reset) begin
      if (nonce_valid) begin
        nv_count++;
        exp_n = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check("nonce_sb", nonce, exp_n);
      end
      if (rx_frame_err) fe_count++;
    end
  end

  // Driver tasks
  task automatic send_work(input logic [255:0] ms, input logic [255:0] d2);
    @(negedge clk);
    midstate   = ms;
    data2      = d2;
    work_valid = 1'b1;
    check("accept_ready", 32'(work_ready), 32'd1);
    check("txd_idle_pre", 32'(TxD), 32'd1);
    @(posedge clk);
    @(negedge clk);
    work_valid = 1'b0;
    check("tx_start_low", 32'(TxD), 32'd0);
    check("ready_drop", 32'(work_ready), 32'd0);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    RxD = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (BC) @(negedge clk);
    end
    RxD = stop_bit;
    repeat (BC) @(negedge clk);
    RxD = 1'b1;
  endtask

  // TX decoder: fills pkt[], records start cycles of first and last byte
  logic [7:0] pkt [64];
  int pkt_first, pkt_last, pkt_errs;

  task automatic capture_packet();
    pkt_errs = 0;
    for (int b = 0; b < 64; b++) begin
      int w = 0;
      while (TxD !== 1'b0 && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (TxD !== 1'b0) begin
        pkt_errs++;
        break;
      end
      if (b == 0) pkt_first = cyc;
      pkt_last = cyc;
      repeat (BC/2 - 1) @(negedge clk);
      if (TxD !== 1'b0) pkt_errs++;
      for (int i = 0; i < 8; i++) begin
        repeat (BC) @(negedge clk);
        pkt[b][i] = TxD;
      end
      repeat (BC) @(negedge clk);
      if (TxD !== 1'b1) pkt_errs++;
    end
  endtask

  function automatic int pkt_mismatches(input logic [511:0] word);
    int m = 0;
    for (int k = 0; k < 64; k++)
      if (pkt[k] !== word[511 - 8*k -: 8]) m++;
    return m;
  endfunction

  int ready_low;
  int bad_txd, bad_rdy, bad_busy, nv0, fe0;
  logic [255:0] ms_a, d2_a, ms_b, d2_b;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 32'(TxD), 32'd1);
    check("rst_ready", 32'(work_ready), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_nonce", nonce, 32'd0);
    check("rst_nonce_valid", 32'(nonce_valid), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    reset = 1'b0;

    // Idle for 50 clocks
    bad_txd = 0; bad_rdy = 0; bad_busy = 0;
    nv0 = nv_count; fe0 = fe_count;
    repeat (50) begin
      @(negedge clk);
      if (TxD !== 1'b1) bad_txd++;
      if (work_ready !== 1'b1) bad_rdy++;
      if (tx_busy !== 1'b0) bad_busy++;
    end
    check("idle_txd", 32'(bad_txd), 32'd0);
    check("idle_ready", 32'(bad_rdy), 32'd0);
    check("idle_busy", 32'(bad_busy), 32'd0);
    check("idle_pulses", 32'(nv_count - nv0 + fe_count - fe0), 32'd0);

    // Full packet, ready timing, ignored second offer
    ms_a = 256'h1;
    d2_a = {8'hA5, 248'h0};
    send_work(ms_a, d2_a);
    check("busy_after_accept", 32'(tx_busy), 32'd1);
    fork
      capture_packet();
      begin
        ready_low = 0;
        while (work_ready !== 1'b1 && ready_low < 7000) begin
          ready_low++;
          @(negedge clk);
        end
      end
      begin
        repeat (500) @(negedge clk);
        check("ready_mid_pkt", 32'(work_ready), 32'd0);
        midstate   = {32{8'hFF}};
        data2      = {32{8'hEE}};
        work_valid = 1'b1;
        repeat (20) @(negedge clk);
        work_valid = 1'b0;
      end
    join
    check("ready_return", 32'(ready_low), 32'd6400);
    check("pkt_framing", 32'(pkt_errs), 32'd0);
    check("byte0", 32'(pkt[0]), 32'h00);
    check("byte31", 32'(pkt[31]), 32'h01);
    check("byte32", 32'(pkt[32]), 32'hA5);
    check("pkt_bytes", 32'(pkt_mismatches({ms_a, d2_a})), 32'd0);
    check("byte_spacing", 32'(pkt_last - pkt_first), 32'd6300);
    bad_txd = 0;
    repeat (30) begin
      @(negedge clk);
      if (TxD !== 1'b1 || tx_busy !== 1'b0) bad_txd++;
    end
    check("no_second_pkt", 32'(bad_txd), 32'd0);

    // Reset at clock 1000 of a packet, then a fresh packet from byte 0
    send_work({32{8'h77}}, {32{8'h77}});
    repeat (998) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_txd", 32'(TxD), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_ready", 32'(work_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("postrst_ready", 32'(work_ready), 32'd1);
    ms_b = {8'h3C, 240'h0, 8'h5A};
    d2_b = {8'h96, 240'h0, 8'hC3};
    send_work(ms_b, d2_b);
    capture_packet();
    check("rst_pkt_framing", 32'(pkt_errs), 32'd0);
    check("rst_byte0", 32'(pkt[0]), 32'h3C);
    check("rst_byte31", 32'(pkt[31]), 32'h5A);
    check("rst_byte32", 32'(pkt[32]), 32'h96);
    check("rst_byte63", 32'(pkt[63]), 32'hC3);
    check("rst_pkt_bytes", 32'(pkt_mismatches({ms_b, d2_b})), 32'd0);
    repeat (20) @(negedge clk);
    check("rst_pkt_done", 32'(work_ready), 32'd1);

    // Nonce 78,56,34,12 back-to-back
    nv0 = nv_count; fe0 = fe_count;
    exp_q.push_back(32'h1234_5678);
    uart_send(8'h78, 1'b1);
    uart_send(8'h56, 1'b1);
    uart_send(8'h34, 1'b1);
    uart_send(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    check("nonce1_pulses", 32'(nv_count - nv0), 32'd1);
    check("nonce1_ferr", 32'(fe_count - fe0), 32'd0);
    check("nonce1_value", nonce, 32'h1234_5678);

    // Bad stop bit, then DEADBEEF
    nv0 = nv_count; fe0 = fe_count;
    uart_send(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    check("ferr_pulse", 32'(fe_count - fe0), 32'd1);
    check("ferr_no_nonce", 32'(nv_count - nv0), 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    uart_send(8'hEF, 1'b1);
    uart_send(8'hBE, 1'b1);
    uart_send(8'hAD, 1'b1);
    uart_send(8'hDE, 1'b1);
    repeat (20) @(negedge clk);
    check("nonce2_pulses", 32'(nv_count - nv0), 32'd1);
    check("nonce2_value", nonce, 32'hDEAD_BEEF);

    // Partial nonce across a 300-clock idle gap
    nv0 = nv_count;
    uart_send(8'hAA, 1'b1);
    uart_send(8'hBB, 1'b1);
    repeat (300) @(negedge clk);
`ifdef WORK_DISPATCH_RX_TIMEOUT_EN
    exp_q.push_back(32'h0000_0001);
`else
    exp_q.push_back(32'h0001_BBAA);
    exp_q.push_back(32'h2211_0000);
`endif
    uart_send(8'h01, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'h00, 1'b1);
    repeat (20) @(negedge clk);
`ifdef WORK_DISPATCH_RX_TIMEOUT_EN
    check("timeout_value", nonce, 32'h0000_0001);
`else
    check("stale_value", nonce, 32'h0001_BBAA);
`endif
    uart_send(8'h11, 1'b1);
    uart_send(8'h22, 1'b1);
    repeat (20) @(negedge clk);
`ifdef WORK_DISPATCH_RX_TIMEOUT_EN
    check("timeout_pulses", 32'(nv_count - nv0), 32'd1);
    check("timeout_final", nonce, 32'h0000_0001);
`else
    check("stale_pulses", 32'(nv_count - nv0), 32'd2);
    check("stale_final", nonce, 32'h2211_0000);
`endif

    // Final report
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
